// File: rtl/note_player.sv
// Beat sequencer and square-wave tone generator driven by a combinational music ROM.
// Define MUSIC_LOOP_EN to replay the song continuously instead of finishing with a done pulse.
module note_player #(
   parameter int unsigned CLK_HZ   = 100000000,
   parameter int unsigned BEAT_HZ  = 4,
   parameter int unsigned SONG_LEN = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        play,
   input  logic        stop,
   output logic [31:0] beat_cnt,
   input  logic [4:0]  note,
   output logic        audio_out,
   output logic        busy,
   output logic        done
);

   localparam logic [31:0] BEAT_LEN  = 32'(CLK_HZ / BEAT_HZ);
   localparam logic [31:0] LAST_TICK = BEAT_LEN - 32'd1;
   localparam logic [31:0] LAST_BEAT = 32'(SONG_LEN - 1);

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   state_t      state_q;
   logic [31:0] beat_q;
   logic [31:0] tick_q;
   logic [4:0]  note_q;
   logic [31:0] tone_q;
   logic        audio_q;
   logic        busy_q;
   logic        done_q;

   logic [31:0] tone_d;
   logic        audio_d;
   logic [31:0] half_per;
   logic        note_valid;

   // Codes 1..8 map to C4..C5; everything else plays as silence
   function automatic logic [31:0] half_period(input logic [4:0] code);
      case (code)
         5'd1:    return 32'(CLK_HZ / (2 * 262));
         5'd2:    return 32'(CLK_HZ / (2 * 294));
         5'd3:    return 32'(CLK_HZ / (2 * 330));
         5'd4:    return 32'(CLK_HZ / (2 * 349));
         5'd5:    return 32'(CLK_HZ / (2 * 392));
         5'd6:    return 32'(CLK_HZ / (2 * 440));
         5'd7:    return 32'(CLK_HZ / (2 * 494));
         5'd8:    return 32'(CLK_HZ / (2 * 523));
         default: return 32'd0;
      endcase
   endfunction

   assign half_per   = half_period(note_q);
   assign note_valid = (note_q != 5'd0) && (note_q <= 5'd8);

   // A newly sampled note restarts the waveform low so every note begins with a full low phase
   always_comb begin
      tone_d  = tone_q;
      audio_d = audio_q;
      if (note != note_q || !note_valid) begin
         tone_d  = 32'd0;
         audio_d = 1'b0;
      end else if (tone_q == half_per - 32'd1) begin
         tone_d  = 32'd0;
         audio_d = ~audio_q;
      end else begin
         tone_d  = tone_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= 32'd0;
         tick_q  <= 32'd0;
         note_q  <= 5'd0;
         tone_q  <= 32'd0;
         audio_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               beat_q  <= 32'd0;
               tick_q  <= 32'd0;
               note_q  <= 5'd0;
               tone_q  <= 32'd0;
               audio_q <= 1'b0;
               done_q  <= 1'b0;
               if (play && !stop) begin
                  state_q <= PLAY;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            PLAY: begin
               if (stop) begin
                  state_q <= IDLE;
                  beat_q  <= 32'd0;
                  tick_q  <= 32'd0;
                  note_q  <= 5'd0;
                  tone_q  <= 32'd0;
                  audio_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  note_q  <= note;
                  tone_q  <= tone_d;
                  audio_q <= audio_d;
                  if (tick_q == LAST_TICK) begin
                     tick_q <= 32'd0;
                     if (beat_q == LAST_BEAT) begin
`ifdef MUSIC_LOOP_EN
                        beat_q  <= 32'd0;
`else
                        state_q <= DONE;
                        beat_q  <= 32'd0;
                        note_q  <= 5'd0;
                        tone_q  <= 32'd0;
                        audio_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                     end else begin
                        beat_q <= beat_q + 32'd1;
                     end
                  end else begin
                     tick_q <= tick_q + 32'd1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               beat_q  <= 32'd0;
               tick_q  <= 32'd0;
               note_q  <= 5'd0;
               tone_q  <= 32'd0;
               audio_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign beat_cnt  = beat_q;
   assign audio_out = audio_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with a small clock, 1000-cycle beats and a descending-scale ROM.
// Honours MUSIC_LOOP_EN the same way the design does.
module tb_note_player;

   logic        clk;
   logic        rst_n;
   logic        play;
   logic        stop;
   logic [31:0] beat_cnt;
   logic [4:0]  note;
   logic        audio_out;
   logic        busy;
   logic        done;

   int checks;
   int failures;
   int t;
   int doneCount;

`ifdef MUSIC_LOOP_EN
   localparam int EXP_DONE = 0;
`else
   localparam int EXP_DONE = 1;
`endif

   note_player #(
      .CLK_HZ  (100000),
      .BEAT_HZ (100),
      .SONG_LEN(9)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .play     (play),
      .stop     (stop),
      .beat_cnt (beat_cnt),
      .note     (note),
      .audio_out(audio_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Music ROM: silence then C5 down to C4
   always_comb begin
      note = 5'd0;
      case (beat_cnt)
         32'd1: note = 5'd8;
         32'd2: note = 5'd7;
         32'd3: note = 5'd6;
         32'd4: note = 5'd5;
         32'd5: note = 5'd4;
         32'd6: note = 5'd3;
         32'd7: note = 5'd2;
         32'd8: note = 5'd1;
         default: note = 5'd0;
      endcase
   end

   always @(negedge clk) begin
      if (done === 1'b1) doneCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic p, input logic s);
      play = p;
      stop = s;
      @(posedge clk);
      #1;
      t++;
      play = 1'b0;
      stop = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   task automatic advanceTo(input int target);
      while (t < target) begin
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   // t counts edges after the one that accepts play
   task automatic startSong();
      play = 1'b1;
      @(posedge clk);
      #1;
      play = 1'b0;
      t = 0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      doneCount = 0;
      t         = 0;
      play      = 1'b0;
      stop      = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("rst_beat", beat_cnt, 32'd0);
      checkOutput("rst_audio", 32'(audio_out), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      waitCycles(20);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_beat", beat_cnt, 32'd0);

      $display("[TB] full song");
      startSong();
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_beat", beat_cnt, 32'd0);
      advanceTo(500);
      checkOutput("silent_audio", 32'(audio_out), 32'd0);
      advanceTo(999);
      checkOutput("beat0_end", beat_cnt, 32'd0);
      checkOutput("silent_audio_end", 32'(audio_out), 32'd0);
      advanceTo(1000);
      checkOutput("beat1_start", beat_cnt, 32'd1);
      advanceTo(1095);
      checkOutput("c5_low", 32'(audio_out), 32'd0);
      advanceTo(1096);
      checkOutput("c5_rise", 32'(audio_out), 32'd1);
      advanceTo(1190);
      checkOutput("c5_high", 32'(audio_out), 32'd1);
      advanceTo(1191);
      checkOutput("c5_fall", 32'(audio_out), 32'd0);
      advanceTo(1500);
      applyStimulus(1'b1, 1'b0);
      checkOutput("replay_busy", 32'(busy), 32'd1);
      checkOutput("replay_beat", beat_cnt, 32'd1);
      advanceTo(1999);
      checkOutput("beat1_end", beat_cnt, 32'd1);
      advanceTo(2000);
      checkOutput("beat2_start", beat_cnt, 32'd2);
      advanceTo(3113);
      checkOutput("a4_low", 32'(audio_out), 32'd0);
      advanceTo(3114);
      checkOutput("a4_rise", 32'(audio_out), 32'd1);
      advanceTo(3226);
      checkOutput("a4_high", 32'(audio_out), 32'd1);
      advanceTo(3227);
      checkOutput("a4_fall", 32'(audio_out), 32'd0);
      for (int n = 4; n <= 8; n++) begin
         advanceTo(1000 * n);
         checkOutput("beat_step", beat_cnt, 32'(n));
      end
      advanceTo(8999);
      checkOutput("last_beat", beat_cnt, 32'd8);
      checkOutput("last_busy", 32'(busy), 32'd1);
      checkOutput("last_done", 32'(done), 32'd0);
      advanceTo(9000);
`ifdef MUSIC_LOOP_EN
      checkOutput("wrap_beat", beat_cnt, 32'd0);
      checkOutput("wrap_busy", 32'(busy), 32'd1);
      checkOutput("wrap_done", 32'(done), 32'd0);
      advanceTo(10000);
      checkOutput("wrap_beat1", beat_cnt, 32'd1);
      advanceTo(26999);
      checkOutput("pass3_last", beat_cnt, 32'd8);
      advanceTo(27000);
      checkOutput("pass3_wrap", beat_cnt, 32'd0);
      checkOutput("pass3_busy", 32'(busy), 32'd1);
      checkOutput("loop_done_count", 32'(doneCount), 32'd0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("loop_stop_busy", 32'(busy), 32'd0);
`else
      checkOutput("done_pulse", 32'(done), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd0);
      checkOutput("done_beat", beat_cnt, 32'd0);
      checkOutput("done_audio", 32'(audio_out), 32'd0);
      advanceTo(9001);
      checkOutput("done_clear", 32'(done), 32'd0);
      checkOutput("after_busy", 32'(busy), 32'd0);
      checkOutput("done_count", 32'(doneCount), 32'd1);
`endif
      waitCycles(10);

      $display("[TB] stop in beat 4");
      startSong();
      advanceTo(4000);
      checkOutput("stop_beat4", beat_cnt, 32'd4);
      advanceTo(4499);
      checkOutput("g4_high", 32'(audio_out), 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("stop_busy", 32'(busy), 32'd0);
      checkOutput("stop_beat", beat_cnt, 32'd0);
      checkOutput("stop_audio", 32'(audio_out), 32'd0);
      checkOutput("stop_done", 32'(done), 32'd0);
      waitCycles(20);
      checkOutput("stop_idle", 32'(busy), 32'd0);
      checkOutput("stop_done_count", 32'(doneCount), 32'(EXP_DONE));

      $display("[TB] play with stop in IDLE");
      applyStimulus(1'b1, 1'b1);
      checkOutput("playstop_busy", 32'(busy), 32'd0);
      waitCycles(5);
      checkOutput("playstop_busy2", 32'(busy), 32'd0);
      checkOutput("playstop_beat", beat_cnt, 32'd0);

      $display("[TB] reset mid-song");
      startSong();
      advanceTo(2550);
      checkOutput("b4_high", 32'(audio_out), 32'd1);
      checkOutput("midrst_beat2", beat_cnt, 32'd2);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midrst_beat", beat_cnt, 32'd0);
      checkOutput("midrst_audio", 32'(audio_out), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      waitCycles(10);
      checkOutput("midrst_idle", 32'(busy), 32'd0);
      checkOutput("midrst_done_count", 32'(doneCount), 32'(EXP_DONE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
